// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: a slow word-addressed RAM on the CPU data port.
// Each access takes LATENCY+1 cycles and holds the CPU with stall until it completes.
module data_memory_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int LATENCY     = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   memRead,
    input  logic                   memWrite,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   stall,
    output logic                   misaligned,
    output logic [COUNT_WIDTH-1:0] readCount,
    output logic [COUNT_WIDTH-1:0] writeCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  stateR;
    state_t                  stateNextS;
    logic [3:0]              waitCntR;
    logic [DEPTH_LOG2-1:0]   wordIdxR;
    logic                    isWriteR;
    logic [1:0]              addrLowR;
    logic [31:0]             readDataR;
    logic                    misalignedR;
    logic [COUNT_WIDTH-1:0]  readCountR;
    logic [COUNT_WIDTH-1:0]  writeCountR;
    logic                    stallS;
    logic [31:0]             memArray [DEPTH];

    logic                    requestS;
    logic [DEPTH_LOG2-1:0]   idxS;
    logic [DEPTH_LOG2-1:0]   curIdxS;
    logic                    curWriteS;
    logic [1:0]              curLowS;
    logic                    enterDoneS;
    logic                    unusedAddrS;

    assign requestS    = memRead | memWrite;
    assign idxS        = address[DEPTH_LOG2+1:2];
    assign unusedAddrS = ^address[31:DEPTH_LOG2+2];

    // With LATENCY=1 DONE is entered straight from IDLE, so the live request is used
    assign curIdxS    = (stateR == IDLE) ? idxS         : wordIdxR;
    assign curWriteS  = (stateR == IDLE) ? memWrite     : isWriteR;
    assign curLowS    = (stateR == IDLE) ? address[1:0] : addrLowR;
    assign enterDoneS = (stateNextS == DONE) && (stateR != DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Next-state logic
    always_comb begin
        stateNextS = IDLE;
        case (stateR)
            IDLE: begin
                if (requestS) begin
                    stateNextS = (LATENCY == 1) ? DONE : BUSY;
                end else begin
                    stateNextS = IDLE;
                end
            end
            BUSY: begin
                if (!requestS) begin
                    stateNextS = IDLE;
                end else if (waitCntR == 4'd0) begin
                    stateNextS = DONE;
                end else begin
                    stateNextS = BUSY;
                end
            end
            DONE:    stateNextS = IDLE;
            default: stateNextS = IDLE;
        endcase
    end

    // Stall output: asserted combinationally on a new request, dropped at once by reset
    always_comb begin
        stallS = 1'b0;
        case (stateR)
            IDLE:    stallS = requestS;
            BUSY:    stallS = 1'b1;
            DONE:    stallS = 1'b0;
            default: stallS = 1'b0;
        endcase
    end

    assign stall = stallS & rst_n;

    // Request capture and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCntR <= 4'd0;
            wordIdxR <= '0;
            isWriteR <= 1'b0;
            addrLowR <= 2'd0;
        end else if (stateR == IDLE && requestS) begin
            waitCntR <= WAIT_INIT;
            wordIdxR <= idxS;
            isWriteR <= memWrite;
            addrLowR <= address[1:0];
        end else if (stateR == BUSY && waitCntR != 4'd0) begin
            waitCntR <= waitCntR - 4'd1;
        end else begin
            waitCntR <= waitCntR;
        end
    end

    // Response registers: loaded on entry to DONE, cleared on leaving it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readDataR   <= 32'd0;
            misalignedR <= 1'b0;
        end else if (enterDoneS) begin
            readDataR   <= curWriteS ? 32'd0 : memArray[curIdxS];
            misalignedR <= |curLowS;
        end else if (stateR == DONE) begin
            readDataR   <= 32'd0;
            misalignedR <= 1'b0;
        end else begin
            readDataR   <= readDataR;
            misalignedR <= misalignedR;
        end
    end

    // Saturating completion counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readCountR  <= '0;
            writeCountR <= '0;
        end else if (stateR == DONE) begin
            if (isWriteR) begin
                if (writeCountR != COUNT_MAX) writeCountR <= writeCountR + COUNT_ONE;
            end else begin
                if (readCountR != COUNT_MAX) readCountR <= readCountR + COUNT_ONE;
            end
        end
    end

    // Write commit on the edge leaving DONE; the array itself is never reset
    always_ff @(posedge clk) begin
        if (stateR == DONE && isWriteR) begin
            memArray[wordIdxR] <= writeData;
        end
    end

    assign readData   = readDataR;
    assign misaligned = misalignedR;
    assign readCount  = readCountR;
    assign writeCount = writeCountR;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: per-cycle vector table plus hand-written
// sequences for abort, mid-access reset and counter saturation.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        misaligned;
    logic [15:0] readCount;
    logic [15:0] writeCount;

    logic [31:0] satReadData;
    logic        satStall;
    logic        satMisaligned;
    logic [2:0]  satReadCount;
    logic [2:0]  satWriteCount;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        expStall;
        logic [31:0] expData;
        logic        expMis;
        logic [15:0] expRc;
        logic [15:0] expWc;
    } vec_t;

    vec_t vecs[$];

    data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(3), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .readData(readData),
        .stall(stall), .misaligned(misaligned),
        .readCount(readCount), .writeCount(writeCount)
    );

    // Narrow-counter instance sharing the same traffic, for saturation checks
    data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(3), .COUNT_WIDTH(3)) satDut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .readData(satReadData),
        .stall(satStall), .misaligned(satMisaligned),
        .readCount(satReadCount), .writeCount(satWriteCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and let combinational outputs settle
    task automatic step(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        memRead   = rd;
        memWrite  = wr;
        address   = addr;
        writeData = wd;
        #1;
    endtask

    task automatic addVec(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic st, input logic [31:0] data, input logic mis,
                          input logic [15:0] rc, input logic [15:0] wc, input int n);
        vec_t v;
        v = '{rd, wr, addr, wd, st, data, mis, rc, wc};
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] doneData;

        // Idle, then write 0x10 <- DEADBEEF
        addVec(1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 16'd0, 16'd0, 1);
        addVec(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 16'd0, 16'd0, 3);
        addVec(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 16'd0, 16'd0, 1);
        // Read 0x10
        addVec(1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 32'h0,        1'b0, 16'd0, 16'd1, 3);
        addVec(1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 16'd0, 16'd1, 1);
        addVec(1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 16'd1, 16'd1, 1);
        // Aliased, misaligned read of 0x412 -> word 4
        addVec(1'b1, 1'b0, 32'h412, 32'h0,        1'b1, 32'h0,        1'b0, 16'd1, 16'd1, 3);
        addVec(1'b1, 1'b0, 32'h412, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 16'd1, 16'd1, 1);
        // Back-to-back sw 0x20 then lw 0x20
        addVec(1'b0, 1'b1, 32'h20,  32'h12345678, 1'b1, 32'h0,        1'b0, 16'd2, 16'd1, 3);
        addVec(1'b0, 1'b1, 32'h20,  32'h12345678, 1'b0, 32'h0,        1'b0, 16'd2, 16'd1, 1);
        addVec(1'b1, 1'b0, 32'h20,  32'h0,        1'b1, 32'h0,        1'b0, 16'd2, 16'd2, 3);
        addVec(1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 32'h12345678, 1'b0, 16'd2, 16'd2, 1);
        addVec(1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 16'd3, 16'd2, 1);
        // Read and write together is a write
        addVec(1'b1, 1'b1, 32'h40,  32'h1,        1'b1, 32'h0,        1'b0, 16'd3, 16'd2, 3);
        addVec(1'b1, 1'b1, 32'h40,  32'h1,        1'b0, 32'h0,        1'b0, 16'd3, 16'd2, 1);
        // Seed 0x30 for the reset test
        addVec(1'b0, 1'b1, 32'h30,  32'h0BADF00D, 1'b1, 32'h0,        1'b0, 16'd3, 16'd3, 3);
        addVec(1'b0, 1'b1, 32'h30,  32'h0BADF00D, 1'b0, 32'h0,        1'b0, 16'd3, 16'd3, 1);
        addVec(1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 16'd3, 16'd4, 1);

        rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; address = 32'h0; writeData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_readData", readData, 32'd0);
        chk("reset_counts", {readCount, writeCount}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].expStall});
            chk($sformatf("v%0d_readData", i), readData, vecs[i].expData);
            chk($sformatf("v%0d_misaligned", i), {31'd0, misaligned}, {31'd0, vecs[i].expMis});
            chk($sformatf("v%0d_readCount", i), {16'd0, readCount}, {16'd0, vecs[i].expRc});
            chk($sformatf("v%0d_writeCount", i), {16'd0, writeCount}, {16'd0, vecs[i].expWc});
        end

        // Request withdrawn during BUSY aborts without a write
        step(1'b0, 1'b1, 32'h50, 32'h77);
        chk("abort_idle_stall", {31'd0, stall}, 32'd1);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort_busy_stall", {31'd0, stall}, 32'd1);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort_after_stall", {31'd0, stall}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort_writeCount", {16'd0, writeCount}, 32'd4);

        // Reset during the second BUSY cycle of a write
        step(1'b0, 1'b1, 32'h30, 32'hAAAA5555);
        step(1'b0, 1'b1, 32'h30, 32'hAAAA5555);
        step(1'b0, 1'b1, 32'h30, 32'hAAAA5555);
        chk("busy2_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_stall", {31'd0, stall}, 32'd0);
        chk("midreset_writeCount", {16'd0, writeCount}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; memRead = 1'b0; memWrite = 1'b0;
        doneData = 32'h0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, 32'h30, 32'h0);
            if (c == 3) doneData = readData;
        end
        chk("midreset_prior_data", doneData, 32'h0BADF00D);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("midreset_readCount", {16'd0, readCount}, 32'd1);
        chk("midreset_writeCount_after", {16'd0, writeCount}, 32'd0);

        // Nine writes: wide counter reaches 9, 3-bit counter holds at 7
        for (int w = 0; w < 9; w++) begin
            for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 32'h60, 32'(w));
            if (w == 7) begin
                step(1'b0, 1'b0, 32'h0, 32'h0);
                chk("sat_reach_7", {29'd0, satWriteCount}, 32'd7);
            end
        end
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("sat_hold_7", {29'd0, satWriteCount}, 32'd7);
        chk("wide_count_9", {16'd0, writeCount}, 32'd9);
        doneData = 32'hFFFFFFFF;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, 32'h60, 32'h0);
            if (c == 3) doneData = readData;
        end
        chk("last_write_data", doneData, 32'd8);

        step(1'b0, 1'b0, 32'h0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
